pci_arbiter: RTL and testbench
==============================

# pci_arbiter

Synthesizable central arbiter for the shared PCI bus in the bench and system top.
- Accepts the active-low REQ lines from up to N_MASTERS bus masters, such as the unsupported-commands master and the behavioural PCI masters.
- Drives one active-low GNT per master using round-robin priority and bus parking.
- Watches FRAME/IRDY to detect bus idle, so it can do hidden arbitration during a transaction and enforce the PCI one-clock GNT gap on an idle bus.
- Revokes the grant from a master that fails to start a transaction within IDLE_TIMEOUT idle clocks.

## Interface
- N_MASTERS, 4: number of requesters, 2..16.
- IDLE_TIMEOUT, 16: idle-bus clocks a granted, requesting master gets to assert FRAME before the grant is revoked.
- PARK_MASTER, 0: index parked on when nobody requests.

- CLK  in  1  bus clock; all logic on posedge.
- RST  in  1  reset; synchronous, active-high.
- REQ  in  N_MASTERS  active-low request per master.
- GNT  out  N_MASTERS  active-low grant, registered; at most one bit low.
- FRAME  in  1  PCI FRAME, active low.
- IRDY  in  1  PCI IRDY, active low.
- owner  out  clog2(N_MASTERS)  index of the current or last grantee.
- timeout  out  1  one-clock pulse when a grant is revoked by the idle timer.

## Operation
- bus_idle = (FRAME === 1) && (IRDY === 1), sampled each posedge. X/Z counts as busy.
- idle_q is bus_idle registered.
- A transaction start is detected when idle_q && FRAME === 0.
- A requester is pending when REQ[i] === 0. Any X on REQ means not pending.
- Round-robin pick: the first pending index scanning owner+1, owner+2, … mod N, wrapping. Owner itself is considered last.
- States:
  - S_GAP: all GNT high. On the next clock, load owner with the pick, or PARK_MASTER if none is pending. Clear the timer. Go to S_GNT.
  - S_GNT: GNT[owner] low. Evaluated in priority order:
    - Transaction start: go to S_BUSY.
    - Bus idle, owner not requesting, another master pending: go to S_GAP.
    - Bus idle, owner requesting, timer == IDLE_TIMEOUT-1, another master pending: go to S_GAP and pulse timeout.
    - Otherwise stay.
    - Timer increments only while in S_GNT with bus idle and owner requesting. It saturates at IDLE_TIMEOUT-1.
  - S_BUSY: a transaction is in progress. The GNT of the bus owner may already be deasserted.
    - Another master pending and bus not idle: hidden arbitration. In the same edge, GNT moves from owner to the pick with no gap. Owner updates, timer clears, go to S_GNT.
    - Bus idle with no re-arbitration done: go to S_GNT with the same owner.
- In S_GNT after hidden arbitration, the new grantee waits. A start is only recognised after idle_q, so the gap rule is automatically met.
- With a sole requester and no others pending, the grant is held indefinitely (parking). The timeout never fires without competition.
- The timer counts IDLE_TIMEOUT values 0..IDLE_TIMEOUT-1 and never wraps.

## Timing
- Reset:
  - GNT = all ones, owner = PARK_MASTER, timeout = 0, state = S_GAP, timer = 0.
  - RST asserted at any time, including mid-transaction, forces these values on the next edge.
- All outputs are registered. REQ/FRAME/IRDY sampled at edge k take effect on GNT after edge k.
- Idle-bus grant change: GNT[old] high at edge k (S_GAP), GNT[new] low at edge k+1. This is exactly one all-high clock.
- Busy-bus grant change: single edge, no all-high clock.
- First grant after reset: park grant one clock after RST is first sampled low.
- Request-to-grant latency, idle bus with the parked owner not requesting: 2 clocks (S_GNT→S_GAP, S_GAP→S_GNT).
- The timeout pulse coincides with the edge entering S_GAP.

## Structure
- Shared package pci_arb_pkg: state enum {S_GAP, S_GNT, S_BUSY}, function clog2, default constants for N_MASTERS, IDLE_TIMEOUT and PARK_MASTER.
- One sub-module, pci_arb_rr_pick: combinational rotating priority encoder. Inputs: pending vector and owner. Outputs: pick index and any_pending.
- The top holds the FSM, timer, owner register and GNT register.

## Test plan
- Reset: RST high 3 clocks with REQ=4'b0000 → GNT=4'b1111 throughout. GNT=4'b1110 one clock after release.
- Single request, idle bus: parked on 0, REQ=4'b1011 → GNT 1110→1111→1011 on consecutive edges, owner=2. Master 2 runs a 1-word write; GNT stays 1011 after it ends.
- Round robin: REQ1 and REQ3 held low, each master doing back-to-back single-phase writes → owner sequence 1,3,1,3. No two GNT bits are ever low together.
- Hidden arbitration: master 1 does a 4-word write; REQ2 drops during the 2nd data phase → GNT 1101→1011 on one edge with no all-ones clock. Master 2 FRAME is first low only after FRAME/IRDY have both been high for ≥1 clock.
- Idle timeout: GNT=0111 and REQ3 low, with no FRAME from master 3 and REQ0 low → after 16 idle clocks, timeout pulses 1 clock and GNT goes 1111 then 1110. Repeating with REQ0 high → GNT stays 0111 and there is no timeout.
- Reset mid-operation: RST pulsed during the 3rd data phase of a master-2 burst → GNT=1111 at the next edge, owner=0 and timeout=0. The park grant returns one clock after release.

Source files
------------

// File: rtl/pci_arb_pkg.sv
// Shared types, defaults and helpers for the PCI bus arbiter.
package pci_arb_pkg;

  typedef enum logic [1:0] {S_GAP, S_GNT, S_BUSY} state_e;

  localparam int unsigned DefNMasters    = 4;
  localparam int unsigned DefIdleTimeout = 16;
  localparam int unsigned DefParkMaster  = 0;

  // Ceiling log2, never less than 1 so index vectors always have a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/pci_arb_rr_pick.sv
// Rotating priority encoder: first pending index after owner, owner itself last.
module pci_arb_rr_pick
  import pci_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = DefNMasters
) (
  input  logic [N_MASTERS-1:0]        pending_i,
  input  logic [clog2(N_MASTERS)-1:0] owner_i,
  output logic [clog2(N_MASTERS)-1:0] pick_o,
  output logic                        any_pending_o
);

  localparam int unsigned OW = clog2(N_MASTERS);

  always_comb begin
    int unsigned idx;
    logic        found;
    pick_o = owner_i;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= N_MASTERS; k++) begin
      idx = (32'(owner_i) + k) % N_MASTERS;
      if (!found && pending_i[idx]) begin
        found  = 1'b1;
        pick_o = OW'(idx);
      end
    end
  end

  assign any_pending_o = |pending_i;

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI arbiter: round-robin, bus parking, hidden arbitration and idle-grant timeout.
module pci_arbiter
  import pci_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS    = DefNMasters,
  parameter int unsigned IDLE_TIMEOUT = DefIdleTimeout,
  parameter int unsigned PARK_MASTER  = DefParkMaster
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [N_MASTERS-1:0]        REQ,
  output logic [N_MASTERS-1:0]        GNT,
  input  logic                        FRAME,
  input  logic                        IRDY,
  output logic [clog2(N_MASTERS)-1:0] owner,
  output logic                        timeout
);

  localparam int unsigned   OW   = clog2(N_MASTERS);
  localparam int unsigned   TW   = clog2(IDLE_TIMEOUT);
  localparam logic [OW-1:0] Park = OW'(PARK_MASTER);
  localparam logic [TW-1:0] TMax = TW'(IDLE_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d, pick;
  logic [TW-1:0]        timer_q, timer_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d, pending;
  logic                 timeout_q, timeout_d, idle_q;
  logic                 bus_idle, start, any_pending, other_pending, owner_req;

  // X/Z on REQ, FRAME or IRDY never counts as asserted or idle.
  always_comb begin
    for (int unsigned i = 0; i < N_MASTERS; i++) pending[i] = (REQ[i] === 1'b0);
  end

  assign bus_idle      = (FRAME === 1'b1) && (IRDY === 1'b1);
  assign start         = idle_q && (FRAME === 1'b0);
  assign owner_req     = pending[owner_q];
  assign other_pending = any_pending && (pick != owner_q);

  pci_arb_rr_pick #(
    .N_MASTERS(N_MASTERS)
  ) u_rr_pick (
    .pending_i    (pending),
    .owner_i      (owner_q),
    .pick_o       (pick),
    .any_pending_o(any_pending)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    case (state_q)
      S_GAP: begin
        owner_d = any_pending ? pick : Park;
        timer_d = '0;
        state_d = S_GNT;
      end
      S_GNT: begin
        if (start) begin
          state_d = S_BUSY;
        end else if (bus_idle && !owner_req && other_pending) begin
          state_d = S_GAP;
        end else if (bus_idle && owner_req && other_pending && timer_q == TMax) begin
          state_d   = S_GAP;
          timeout_d = 1'b1;
        end else if (bus_idle && owner_req && timer_q != TMax) begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_BUSY: begin
        // Hidden arbitration: hand over while the current transaction still runs.
        if (other_pending && !bus_idle) begin
          owner_d = pick;
          timer_d = '0;
          state_d = S_GNT;
        end else if (bus_idle) begin
          state_d = S_GNT;
        end
      end
      default: state_d = S_GAP;
    endcase
    gnt_d = '1;
    if (state_d != S_GAP) gnt_d[owner_d] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    idle_q <= bus_idle;
    if (RST) begin
      state_q   <= S_GAP;
      owner_q   <= Park;
      timer_q   <= '0;
      gnt_q     <= '1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      timer_q   <= timer_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign GNT     = gnt_q;
  assign owner   = owner_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Self-checking bench for pci_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_pci_arbiter;

  localparam int N    = 4;
  localparam int IT   = 16;
  localparam int PARK = 0;

  logic       CLK = 1'b0;
  logic       RST, FRAME, IRDY, timeout;
  logic [3:0] REQ, GNT;
  logic [1:0] owner;

  always #5 CLK = ~CLK;

  pci_arbiter #(
    .N_MASTERS   (N),
    .IDLE_TIMEOUT(IT),
    .PARK_MASTER (PARK)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (REQ),
    .GNT    (GNT),
    .FRAME  (FRAME),
    .IRDY   (IRDY),
    .owner  (owner),
    .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the grant, whether a transaction is under way, idle wait count.
  bit m_valid, m_busy, m_to;
  bit m_idle_prev = 1'b1;
  int m_own = PARK;
  int m_wait;

  function automatic int scan(input logic [3:0] req, input int from, input bit incl);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (from + k) % N;
      if (req[idx] == 1'b0 && (k < N || incl)) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    return m_valid ? ~(4'b0001 << m_own) : 4'b1111;
  endfunction

  task automatic model_edge();
    bit idle;
    int other, pick;
    idle = FRAME && IRDY;
    if (RST) begin
      m_valid = 0; m_busy = 0; m_own = PARK; m_wait = 0; m_to = 0;
    end else begin
      other = scan(REQ, m_own, 1'b0);
      m_to  = 0;
      if (!m_valid) begin
        pick    = scan(REQ, m_own, 1'b1);
        m_own   = (pick < 0) ? PARK : pick;
        m_valid = 1; m_busy = 0; m_wait = 0;
      end else if (!m_busy) begin
        if (m_idle_prev && !FRAME) m_busy = 1;
        else if (idle && REQ[m_own] && other >= 0) m_valid = 0;
        else if (idle && !REQ[m_own] && other >= 0 && m_wait == IT - 1) begin
          m_valid = 0; m_to = 1;
        end else if (idle && !REQ[m_own] && m_wait < IT - 1) m_wait++;
      end else begin
        if (other >= 0 && !idle) begin
          m_own = other; m_wait = 0; m_busy = 0;
        end else if (idle) m_busy = 0;
      end
    end
    m_idle_prev = idle;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check("gnt", GNT, exp_gnt());
    check("owner", owner, m_own);
    check("timeout", timeout, m_to);
  endtask

  task automatic bus(input logic f, input logic i);
    FRAME = f;
    IRDY  = i;
    step();
  endtask

  task automatic wait_gnt(input logic [3:0] want, input string tag);
    int n;
    n = 0;
    while (GNT !== want && n < 40) begin
      step();
      n++;
    end
    check(tag, GNT, want);
  endtask

  initial begin
    int   starters[$];
    int   ph, gapw;
    bit   prev_idle, quiet;

    // Reset held with everyone requesting, then released with no requests: park on 0.
    RST = 1'b1; REQ = 4'b0000; FRAME = 1'b1; IRDY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_gnt", GNT, 4'b1111);
    end
    RST = 1'b0; REQ = 4'b1111;
    step();
    check("park_gnt", GNT, 4'b1110);
    check("park_owner", owner, 0);

    // Single request on an idle bus: one all-high clock, then grant.
    REQ = 4'b1011;
    step();
    check("sr_gap", GNT, 4'b1111);
    step();
    check("sr_gnt", GNT, 4'b1011);
    check("sr_owner", owner, 2);
    bus(1'b0, 1'b1);
    REQ = 4'b1111;
    bus(1'b1, 1'b0);
    bus(1'b1, 1'b1);
    check("sr_park", GNT, 4'b1011);

    // Round robin between masters 1 and 3, back-to-back single-phase writes.
    REQ = 4'b0101; ph = 0; prev_idle = 1'b1; gapw = 0;
    for (int c = 0; c < 80 && starters.size() < 6; c++) begin
      int m;
      m = -1;
      for (int j = 0; j < N; j++) if (GNT[j] == 1'b0) m = j;
      FRAME = 1'b1; IRDY = 1'b1;
      if (ph == 1) begin
        IRDY = 1'b0; ph = 2;
      end else if (ph == 2) begin
        ph = 0; gapw = $urandom_range(0, 2);
      end else if (gapw > 0) begin
        gapw--;
      end else if (prev_idle && m >= 0 && REQ[m] == 1'b0) begin
        FRAME = 1'b0; starters.push_back(m); ph = 1;
      end
      prev_idle = FRAME && IRDY;
      step();
    end
    if (ph == 1) bus(1'b1, 1'b0);
    bus(1'b1, 1'b1);
    check("rr_count", starters.size(), 6);
    if (starters.size() > 0) check("rr_first", starters[0], 3);
    for (int i = 1; i < starters.size(); i++)
      check("rr_alt", starters[i], (starters[i-1] == 3) ? 1 : 3);

    // Hidden arbitration: master 1 four-word write, REQ2 drops in data phase 2.
    REQ = 4'b1101;
    wait_gnt(4'b1101, "ha_setup");
    bus(1'b0, 1'b1);
    bus(1'b0, 1'b0);
    check("ha_hold", GNT, 4'b1101);
    REQ = 4'b1001;
    bus(1'b0, 1'b0);
    check("ha_move", GNT, 4'b1011);
    bus(1'b0, 1'b0);
    bus(1'b1, 1'b0);
    bus(1'b1, 1'b1);
    REQ = 4'b1011;
    bus(1'b0, 1'b1);
    REQ = 4'b1111;
    bus(1'b1, 1'b0);
    bus(1'b1, 1'b1);

    // Idle timeout with competition from master 0.
    REQ = 4'b0111;
    wait_gnt(4'b0111, "to_setup");
    REQ = 4'b0110;
    for (int k = 0; k < IT - 1; k++) begin
      step();
      check("to_wait", timeout, 1'b0);
    end
    step();
    check("to_pulse", timeout, 1'b1);
    check("to_gap", GNT, 4'b1111);
    step();
    check("to_regrant", GNT, 4'b1110);
    check("to_clear", timeout, 1'b0);

    // No competition: grant is held and the timer never fires.
    REQ = 4'b0111;
    wait_gnt(4'b0111, "nto_setup");
    for (int k = 0; k < IT + 8; k++) begin
      step();
      check("nto_gnt", GNT, 4'b0111);
      check("nto_pulse", timeout, 1'b0);
    end

    // Reset in data phase 3 of a master-2 burst.
    REQ = 4'b1011;
    wait_gnt(4'b1011, "mr_setup");
    bus(1'b0, 1'b1);
    bus(1'b0, 1'b0);
    bus(1'b0, 1'b0);
    RST = 1'b1;
    bus(1'b0, 1'b0);
    check("mr_gnt", GNT, 4'b1111);
    check("mr_owner", owner, 0);
    check("mr_to", timeout, 1'b0);
    RST = 1'b0; REQ = 4'b1111;
    bus(1'b1, 1'b1);
    check("mr_park", GNT, 4'b1110);

    // Random traffic; quiet stretches let the idle timer run out.
    quiet = 1'b0;
    for (int c = 0; c < 600; c++) begin
      RST = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) REQ = 4'($urandom);
      if ($urandom_range(0, 19) == 0) quiet = ~quiet;
      FRAME = quiet ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      IRDY  = quiet ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
